// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor: FSM state encoding,
// default operand width and counter sizing.
package serial_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Bits needed to count 0..w-1; never narrower than one bit.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bin, with the borrow out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first, one bit per clock).
// Define SERIAL_SUBTRACTOR_SIGNED_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int            CW       = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             bin_q, bin_d;
   logic             borrow_q, borrow_d;
   logic             fs_d, fs_bout;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   full_subtractor u_cell (
      .x    (a_q[0]),
      .y    (b_q[0]),
      .bin  (bin_q),
      .d    (fs_d),
      .bout (fs_bout)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      bin_d    = bin_q;
      borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               bin_d   = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Result fills from the top so it is aligned after WIDTH shifts.
            res_d = {fs_d, res_q[WIDTH-1:1]};
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            bin_d = fs_bout;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               borrow_d = fs_bout;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
               ovf_d    = bin_q ^ fs_bout;
`endif
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         bin_q    <= 1'b0;
         borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         bin_q    <= bin_d;
         borrow_q <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign diff      = res_q;
   assign borrow    = borrow_q;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule
